// File: rtl/nemo_yaw_reader.sv
// NEMO yaw-rate reader: configures the NEMO inertial sensor over the SPI
// monarch after power-up, then reads the 16-bit yaw rate on every data-ready
// interrupt and presents it to the heading integrator with a one-cycle vld.
module nemo_yaw_reader #(
    parameter int          STARTUP_BITS = 16,
    parameter logic [15:0] CFG_INT      = 16'h0D02,
    parameter logic [15:0] CFG_GYRO     = 16'h1160,
    parameter logic [15:0] CFG_ROUND    = 16'h1460,
    parameter logic [15:0] RD_YAWL      = 16'hA600,
    parameter logic [15:0] RD_YAWH      = 16'hA700
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] inert_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] yaw_rt,
    output logic        vld,
    output logic        setup_done
);

    // CFGx/RDH are entered from a GAP state and issue their wrt in the first
    // cycle (flagged by issue_q); WAIT_PU and IDLE issue on their exit edge.
    typedef enum logic [3:0] {
        WAIT_PU,
        CFG1,
        GAP1,
        CFG2,
        GAP2,
        CFG3,
        IDLE,
        RDL,
        GAPR,
        RDH
    } state_t;

    state_t                  state_q, state_d;
    logic [STARTUP_BITS-1:0] timer_q, timer_d;
    logic                    issue_q, issue_d;
    logic [15:0]             cmd_q, cmd_d;
    logic [7:0]              yawl_q, yawl_d;
    logic [15:0]             yaw_rt_q, yaw_rt_d;
    logic                    vld_q, vld_d;
    logic                    setup_done_q, setup_done_d;
    logic                    int_s1_q, int_s2_q;
    logic                    wrt_c;
    logic                    unused_hi;

    // Only the low byte of each SPI read carries sensor data.
    assign unused_hi = ^inert_data[15:8];

    // Two-flop synchronizer for the asynchronous data-ready pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_s1_q <= 1'b0;
            int_s2_q <= 1'b0;
        end else begin
            int_s1_q <= INT;
            int_s2_q <= int_s1_q;
        end
    end

    // State, timer, command and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT_PU;
            timer_q      <= '0;
            issue_q      <= 1'b0;
            cmd_q        <= 16'h0000;
            yawl_q       <= 8'h00;
            yaw_rt_q     <= 16'h0000;
            vld_q        <= 1'b0;
            setup_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            issue_q      <= issue_d;
            cmd_q        <= cmd_d;
            yawl_q       <= yawl_d;
            yaw_rt_q     <= yaw_rt_d;
            vld_q        <= vld_d;
            setup_done_q <= setup_done_d;
        end
    end

    // Sequencing: power-up wait, three config writes, then yaw read pairs.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        issue_d      = 1'b0;
        cmd_d        = cmd_q;
        yawl_d       = yawl_q;
        yaw_rt_d     = yaw_rt_q;
        vld_d        = 1'b0;
        setup_done_d = setup_done_q;
        wrt_c        = 1'b0;

        case (state_q)
            WAIT_PU: begin
                if (timer_q == '1) begin
                    wrt_c   = 1'b1;
                    cmd_d   = CFG_INT;
                    state_d = CFG1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            CFG1: begin
                if (done) begin
                    state_d = GAP1;
                end
            end
            GAP1: begin
                state_d = CFG2;
                issue_d = 1'b1;
            end
            CFG2: begin
                if (issue_q) begin
                    wrt_c = 1'b1;
                    cmd_d = CFG_GYRO;
                end else if (done) begin
                    state_d = GAP2;
                end
            end
            GAP2: begin
                state_d = CFG3;
                issue_d = 1'b1;
            end
            CFG3: begin
                if (issue_q) begin
                    wrt_c = 1'b1;
                    cmd_d = CFG_ROUND;
                end else if (done) begin
                    setup_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            IDLE: begin
                if (int_s2_q) begin
                    wrt_c   = 1'b1;
                    cmd_d   = RD_YAWL;
                    state_d = RDL;
                end
            end
            RDL: begin
                if (done) begin
                    yawl_d  = inert_data[7:0];
                    state_d = GAPR;
                end
            end
            GAPR: begin
                state_d = RDH;
                issue_d = 1'b1;
            end
            RDH: begin
                if (issue_q) begin
                    wrt_c = 1'b1;
                    cmd_d = RD_YAWH;
                end else if (done) begin
                    yaw_rt_d = {inert_data[7:0], yawl_q};
                    vld_d    = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = WAIT_PU;
            end
        endcase
    end

    assign wrt        = wrt_c;
    assign cmd        = cmd_d;
    assign yaw_rt     = yaw_rt_q;
    assign vld        = vld_q;
    assign setup_done = setup_done_q;

endmodule
